cpu_step_ctrl: RTL

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

---
 rtl/cpu_clk_pkg.sv | 21 ++
 rtl/cpu_step_ctrl_if.sv | 27 ++
 rtl/btn_debounce.sv | 73 +++++++
 rtl/cpu_step_ctrl.sv | 70 +++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// rtl/cpu_clk_pkg.sv - shared debounce state encoding and defaults for the CPU step controller
// Purpose: debounce FSM state type, default parameters and the debounce counter width helper.
// Ports: none (package).
package cpu_clk_pkg;

  localparam int DB_CYCLES_DEFAULT = 20000;
  localparam int CNT_W_DEFAULT     = 16;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // ceil(log2(cycles)), at least one bit so tiny DB_CYCLES still elaborate
  function automatic int db_cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_if.sv
// rtl/cpu_step_ctrl_if.sv - control/status bundle between the board and the CPU step controller
// Purpose: groups the asynchronous board inputs, halt and the CPU advance outputs.
// Ports (signals): clk_sys, btn_step, sw_run, halt (to controller);
//                  cpu_en, step_count[CNT_W], run_mode (from controller).
interface cpu_step_ctrl_if
  import cpu_clk_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
);
  logic             clk_sys;
  logic             btn_step;
  logic             sw_run;
  logic             halt;
  logic             cpu_en;
  logic [CNT_W-1:0] step_count;
  logic             run_mode;

  modport master (
    output clk_sys, btn_step, sw_run, halt,
    input  cpu_en, step_count, run_mode
  );

  modport slave (
    input  clk_sys, btn_step, sw_run, halt,
    output cpu_en, step_count, run_mode
  );
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer plus debounce FSM for the single-step button
// Purpose: emits one step_pulse per accepted press, however long the button is held.
// Ports: clk, rst_n (async active-low), btn (raw async button), step_pulse (1-cycle pulse).
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step_pulse
);

  localparam int            CW   = db_cnt_width(DB_CYCLES);
  // The counter starts at 0 on entry, so leaving when the pre-increment value is
  // DB_CYCLES-2 means the incremented value reaches DB_CYCLES-1 and never wraps.
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 2);

  logic          btn_s1;
  logic          btn_s2;
  db_state_t     state;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= 1'b0;
      btn_s2     <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      step_pulse <= 1'b0;
    end else begin
      btn_s1     <= btn;
      btn_s2     <= btn_s1;
      step_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s2) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              state      <= HELD;
              step_pulse <= 1'b1;
            end
          end
        end
        HELD: begin
          if (!btn_s2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s2) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// rtl/cpu_step_ctrl.sv - CPU advance enable generator: free-run from clk_sys or debounced single step
// Purpose: issues one-cycle cpu_en pulses from clk_sys rising edges (run mode) or accepted
//          button presses (step mode), gated by halt, and counts the pulses issued.
// Ports: clk, rst_n (async active-low); bus (slave): clk_sys, btn_step, sw_run, halt in;
//        cpu_en, step_count, run_mode out.
module cpu_step_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = CNT_W_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  cpu_step_ctrl_if.slave bus
);

  logic             sys_s1;
  logic             sys_s2;
  logic             sys_prev;
  logic             sw_s1;
  logic             sw_s2;
  logic             run_q;
  logic             en_q;
  logic [CNT_W-1:0] count_q;
  logic             step_pulse;
  logic             tick;
  logic             en_next;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (bus.btn_step),
    .step_pulse (step_pulse)
  );

  assign tick = sys_s2 & ~sys_prev;

  // run_q is the registered mode, so an event coinciding with a mode change uses the old mode;
  // the source not selected is simply dropped, as is anything arriving while halted.
  assign en_next = (run_q ? tick : step_pulse) & ~bus.halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_s1   <= 1'b0;
      sys_s2   <= 1'b0;
      sys_prev <= 1'b0;
      sw_s1    <= 1'b0;
      sw_s2    <= 1'b0;
      run_q    <= 1'b0;
      en_q     <= 1'b0;
      count_q  <= '0;
    end else begin
      sys_s1   <= bus.clk_sys;
      sys_s2   <= sys_s1;
      sys_prev <= sys_s2;
      sw_s1    <= bus.sw_run;
      sw_s2    <= sw_s1;
      run_q    <= sw_s2;
      en_q     <= en_next;
      if (en_next) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.cpu_en     = en_q;
  assign bus.step_count = count_q;
  assign bus.run_mode   = run_q;

endmodule
